reg_src_fetch: RTL and testbench
================================

# reg_src_fetch

Operand-read sequencer for the multicycle CPU: the read-side counterpart of the write-destination select. It picks each ALU operand's source register (rs, rt, $ra or $sp), fetches them one after the other through a single registered read port of the register bank, and latches them into the A/B operand registers. Write-back traffic, whose destination comes from the write-destination select, is forwarded so operands never hold stale values. The control unit starts it with a pulse and waits for `done`.

## Interface
- `DATA_W`, 32, register width
- `IDX_W`, 5, register index width
- `RA_IDX`, 31, link register index
- `SP_IDX`, 29, stack pointer index

- `clk`  in  1  clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `Src_A`  in  2  operand A source: 00 rs, 01 rt, 10 RA_IDX, 11 SP_IDX
- `Src_B`  in  2  operand B source, same encoding
- `rs`, `rt`  in  IDX_W  instruction register fields
- `rf_rd_addr`  out  IDX_W  register bank read address
- `rf_rd_data`  in  DATA_W  bank read data; valid the cycle after the address
- `Reg_Write`  in  1  write-back enable, in flight this cycle
- `wr_addr`  in  IDX_W  write-back destination index
- `wr_data`  in  DATA_W  write-back data
- `a_out`, `b_out`  out  DATA_W  latched operands
- `busy`  out  1  high in RD_A, RD_B, CAP_B
- `done`  out  1  one-cycle pulse in DONE

## Operation
- States: IDLE → RD_A → RD_B → CAP_B → DONE → IDLE. All transitions after RD_A are unconditional.
- IDLE with `start`=1: latch `idxA`/`idxB` from Src_A/Src_B, rs, rt and go to RD_A. Later changes on rs, rt or Src_* have no effect.
- `start` outside IDLE (including DONE) is ignored, not queued.
- `rf_rd_addr` by state:
  - RD_A: `idxA`
  - RD_B: `idxB`
  - all other states: 0
- Edge ending RD_B: `a_out` ← operand A value. Edge ending CAP_B: `b_out` ← operand B value.
- Operand value, in priority order:
  - index 0 → 0, regardless of `rf_rd_data` or forwarding
  - a forward is held → forwarded data
  - otherwise → `rf_rd_data`
- Forwarding:
  - A forward is captured when `Reg_Write`=1 and `wr_addr` equals the operand index (nonzero).
  - Window for A: RD_A and RD_B. Window for B: RD_B and CAP_B.
  - Per-operand hold registers keep the latest matching write; a later write in the window overwrites an earlier one.
  - Hold registers clear on entry to RD_A.
  - A same-cycle matching write at the capture edge wins.
- `idxA`==`idxB` is legal. The two operands are fetched and forwarded independently and give equal results unless a write lands between the two captures.
- `a_out`/`b_out` hold their values from capture until the next capture.

## Timing
- `start` sampled at edge k. Then:
  - RD_A during cycle k+1
  - RD_B during k+2 (`a_out` valid from k+3)
  - CAP_B during k+3
  - DONE during k+4 (`done`=1, `b_out` valid)
  - IDLE during k+5
- Earliest next accepted `start`: sampled at the edge ending k+5.
- Reset (`reset`=0 at an edge), including mid-sequence:
  - state → IDLE
  - `a_out`, `b_out` → 0
  - `busy`, `done` → 0
  - `rf_rd_addr` → 0
  - forward holds cleared
  - No partial capture survives.
- `busy` and `done` are never high together. `busy`=0 in IDLE and DONE.

## Structure
- Shared package `cpu_reg_pkg`:
  - `SRC_RS`/`SRC_RT`/`SRC_RA`/`SRC_SP` 2-bit encodings
  - `RA_IDX`, `SP_IDX`
  - fetch state enum
- Sub-module `src_idx_sel`: combinational 2-bit select → index, instantiated once per operand.

## Test plan
- Reg bank holds r8=0x11, r9=0x22. Src_A=00, Src_B=01, rs=8, rt=9, `start` at k → `rf_rd_addr` 8 at k+1 and 9 at k+2; `a_out`=0x11 from k+3; `done`=1 only at k+4 with `b_out`=0x22.
- Src_A=10, Src_B=11, r31=0x400, r29=0x7FFC → `rf_rd_addr` 31 then 29; `a_out`=0x400, `b_out`=0x7FFC.
- rs=0, bank returns 0xDEAD for index 0 → `a_out`=0. `Reg_Write` to r0 in the window → still 0.
- rs=rt=9:
  - Reg_Write r9=0x55 during RD_A, then r9=0x66 during CAP_B → `a_out`=0x55, `b_out`=0x66.
  - Second run: Reg_Write r9=0x55 in RD_A and r9=0x77 in RD_B → `a_out`=0x77.
- `reset`=0 during RD_B → next cycle IDLE, `a_out`=`b_out`=0, no `done`. `start` pulses in RD_A and in DONE → ignored, exactly one `done` per accepted start.

Source files
------------

// File: rtl/cpu_reg_pkg.sv
// Shared register-file definitions: operand source encodings, fixed register
// indices and the operand-fetch state encoding.
package cpu_reg_pkg;

  localparam logic [1:0] SRC_RS = 2'b00;
  localparam logic [1:0] SRC_RT = 2'b01;
  localparam logic [1:0] SRC_RA = 2'b10;
  localparam logic [1:0] SRC_SP = 2'b11;

  localparam int unsigned RA_IDX = 31;
  localparam int unsigned SP_IDX = 29;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP_B = 3'd3,
    DONE  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/src_idx_sel.sv
// Maps a 2-bit operand source select onto a register index.
module src_idx_sel
  import cpu_reg_pkg::*;
#(
  parameter int unsigned IDX_W = 5
) (
  input  logic [1:0]       src,
  input  logic [IDX_W-1:0] rs,
  input  logic [IDX_W-1:0] rt,
  output logic [IDX_W-1:0] idx_c
);

  always_comb begin
    idx_c = rs;
    case (src)
      SRC_RS:  idx_c = rs;
      SRC_RT:  idx_c = rt;
      SRC_RA:  idx_c = IDX_W'(RA_IDX);
      SRC_SP:  idx_c = IDX_W'(SP_IDX);
      default: idx_c = rs;
    endcase
  end

endmodule

// File: rtl/reg_src_fetch.sv
// Operand-read sequencer: fetches A then B through one registered bank read
// port, forwarding in-flight write-back data, and latches them into a_out/b_out.
module reg_src_fetch
  import cpu_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        Src_A,
  input  logic [1:0]        Src_B,
  input  logic [IDX_W-1:0]  rs,
  input  logic [IDX_W-1:0]  rt,
  output logic [IDX_W-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              Reg_Write,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              busy,
  output logic              done
);

  fetch_state_t state, nxt;

  logic [IDX_W-1:0]  sel_a_c, sel_b_c;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic              fwd_a_vld, fwd_b_vld;
  logic [DATA_W-1:0] fwd_a_data, fwd_b_data;

  logic              hit_a, hit_b, win_a, win_b;
  logic [DATA_W-1:0] op_a, op_b;
  logic [IDX_W-1:0]  addr_nxt;
  logic              busy_nxt, done_nxt;

  src_idx_sel #(.IDX_W(IDX_W)) u_sel_a (.src(Src_A), .rs(rs), .rt(rt), .idx_c(sel_a_c));
  src_idx_sel #(.IDX_W(IDX_W)) u_sel_b (.src(Src_B), .rs(rs), .rt(rt), .idx_c(sel_b_c));

  // Next state plus registered-output lookahead
  always_comb begin
    nxt      = state;
    addr_nxt = '0;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state)
      IDLE:    if (start) nxt = RD_A;
      RD_A:    nxt = RD_B;
      RD_B:    nxt = CAP_B;
      CAP_B:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    case (nxt)
      RD_A:    begin addr_nxt = sel_a_c; busy_nxt = 1'b1; end
      RD_B:    begin addr_nxt = idx_b;   busy_nxt = 1'b1; end
      CAP_B:   busy_nxt = 1'b1;
      DONE:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Operand selection: r0 forced to zero, then same-cycle write, held forward, bank
  always_comb begin
    win_a = (state == RD_A) || (state == RD_B);
    win_b = (state == RD_B) || (state == CAP_B);
    hit_a = Reg_Write && (wr_addr == idx_a) && (idx_a != '0);
    hit_b = Reg_Write && (wr_addr == idx_b) && (idx_b != '0);
    op_a  = rf_rd_data;
    op_b  = rf_rd_data;
    if (idx_a == '0)    op_a = '0;
    else if (hit_a)     op_a = wr_data;
    else if (fwd_a_vld) op_a = fwd_a_data;
    if (idx_b == '0)    op_b = '0;
    else if (hit_b)     op_b = wr_data;
    else if (fwd_b_vld) op_b = fwd_b_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      rf_rd_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      idx_a      <= '0;
      idx_b      <= '0;
      fwd_a_vld  <= 1'b0;
      fwd_b_vld  <= 1'b0;
      fwd_a_data <= '0;
      fwd_b_data <= '0;
      a_out      <= '0;
      b_out      <= '0;
    end else begin
      state      <= nxt;
      rf_rd_addr <= addr_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      if (state == IDLE && start) begin
        idx_a     <= sel_a_c;
        idx_b     <= sel_b_c;
        fwd_a_vld <= 1'b0;
        fwd_b_vld <= 1'b0;
      end
      if (win_a && hit_a) begin
        fwd_a_vld  <= 1'b1;
        fwd_a_data <= wr_data;
      end
      if (win_b && hit_b) begin
        fwd_b_vld  <= 1'b1;
        fwd_b_data <= wr_data;
      end
      if (state == RD_B)  a_out <= op_a;
      if (state == CAP_B) b_out <= op_b;
    end
  end

endmodule

// File: tb/tb_reg_src_fetch.sv
// Randomized and directed bench for reg_src_fetch with a behavioural register
// bank and an operand reference model built from the forwarding rules.
module tb_reg_src_fetch;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    Src_A, Src_B;
  logic [IW-1:0] rs, rt;
  logic [IW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic          Reg_Write;
  logic [IW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] a_out, b_out;
  logic          busy, done;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem [0:31];

  // Per-cycle write-back plan: 0 = start cycle, 1 = RD_A, 2 = RD_B, 3 = CAP_B, 4 = DONE
  logic          we_q [0:4];
  logic [IW-1:0] wa_q [0:4];
  logic [DW-1:0] wd_q [0:4];

  always #5 clk = ~clk;

  reg_src_fetch #(.DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .Src_A(Src_A), .Src_B(Src_B),
    .rs(rs), .rt(rt), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .Reg_Write(Reg_Write), .wr_addr(wr_addr), .wr_data(wr_data),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done)
  );

  // Register bank: registered read (read-before-write), r0 returns junk
  always @(posedge clk) begin
    rf_rd_data <= (rf_rd_addr == 5'd0) ? 32'hDEAD : mem[rf_rd_addr];
    if (Reg_Write) mem[wr_addr] <= wr_data;
  end

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] idx_of(input logic [1:0] s, input logic [IW-1:0] r_s,
                                           input logic [IW-1:0] r_t);
    case (s)
      2'd0:    return r_s;
      2'd1:    return r_t;
      2'd2:    return 5'd31;
      default: return 5'd29;
    endcase
  endfunction

  // Operand = last matching write inside its window, else the bank snapshot; r0 always 0
  function automatic logic [DW-1:0] expect_op(input logic [IW-1:0] idx, input logic [DW-1:0] snap,
                                              input int first);
    logic [DW-1:0] v;
    if (idx == 5'd0) return '0;
    v = snap;
    for (int c = first; c <= first + 1; c++)
      if (we_q[c] && wa_q[c] == idx) v = wd_q[c];
    return v;
  endfunction

  task automatic clr_plan();
    for (int c = 0; c < 5; c++) begin
      we_q[c] = 1'b0; wa_q[c] = '0; wd_q[c] = '0;
    end
  endtask

  task automatic drive_wr(input int c);
    Reg_Write = we_q[c];
    wr_addr   = wa_q[c];
    wr_data   = wd_q[c];
  endtask

  task automatic bank_wr(input logic [IW-1:0] a, input logic [DW-1:0] d);
    Reg_Write = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    Reg_Write = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] sa, input logic [1:0] sb,
                        input logic [IW-1:0] r_s, input logic [IW-1:0] r_t, input bit spam);
    logic [IW-1:0] ia, ib;
    logic [DW-1:0] snap_a, snap_b, ea, eb;
    ia = idx_of(sa, r_s, r_t);
    ib = idx_of(sb, r_s, r_t);
    start = 1'b1; Src_A = sa; Src_B = sb; rs = r_s; rt = r_t;
    drive_wr(0);
    @(posedge clk); #1;                           // RD_A
    snap_a = mem[ia];
    start = spam; Src_A = 2'($urandom); Src_B = 2'($urandom);
    rs = 5'($urandom); rt = 5'($urandom);
    drive_wr(1);
    check_val("addr_rd_a", 32'(rf_rd_addr), 32'(ia));
    check_val("busy_rd_a", 32'(busy), 32'd1);
    check_val("done_rd_a", 32'(done), 32'd0);
    @(posedge clk); #1;                           // RD_B
    snap_b = mem[ib];
    start = 1'b0;
    drive_wr(2);
    check_val("addr_rd_b", 32'(rf_rd_addr), 32'(ib));
    @(posedge clk); #1;                           // CAP_B
    drive_wr(3);
    ea = expect_op(ia, snap_a, 1);
    check_val("a_out", a_out, ea);
    check_val("addr_cap_b", 32'(rf_rd_addr), 32'd0);
    check_val("busy_cap_b", 32'(busy), 32'd1);
    @(posedge clk); #1;                           // DONE
    drive_wr(4);
    start = spam;
    eb = expect_op(ib, snap_b, 2);
    check_val("done_pulse", 32'(done), 32'd1);
    check_val("busy_done", 32'(busy), 32'd0);
    check_val("b_out", b_out, eb);
    check_val("a_out_hold", a_out, ea);
    @(posedge clk); #1;                           // IDLE
    start = 1'b0; Reg_Write = 1'b0;
    check_val("done_idle", 32'(done), 32'd0);
    check_val("busy_idle", 32'(busy), 32'd0);
    check_val("b_out_hold", b_out, eb);
    @(posedge clk); #1;
    check_val("no_queued_start", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; Src_A = '0; Src_B = '0; rs = '0; rt = '0;
    Reg_Write = 1'b0; wr_addr = '0; wr_data = '0;
    clr_plan();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_a", a_out, '0);
    check_val("rst_b", b_out, '0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_addr", 32'(rf_rd_addr), 32'd0);
    reset = 1'b1;

    for (int r = 1; r < 32; r++) bank_wr(5'(r), $urandom);
    bank_wr(5'd8, 32'h11);
    bank_wr(5'd9, 32'h22);
    bank_wr(5'd31, 32'h400);
    bank_wr(5'd29, 32'h7FFC);

    clr_plan();
    run_op(2'd0, 2'd1, 5'd8, 5'd9, 1'b0);
    run_op(2'd2, 2'd3, 5'd3, 5'd4, 1'b0);

    // r0 operand with writes to r0 in the A window
    clr_plan();
    we_q[1] = 1'b1; wa_q[1] = 5'd0; wd_q[1] = 32'h1234;
    we_q[2] = 1'b1; wa_q[2] = 5'd0; wd_q[2] = 32'h5678;
    run_op(2'd0, 2'd1, 5'd0, 5'd8, 1'b0);

    // Same index for both operands, write lands between the captures
    clr_plan();
    we_q[1] = 1'b1; wa_q[1] = 5'd9; wd_q[1] = 32'h55;
    we_q[3] = 1'b1; wa_q[3] = 5'd9; wd_q[3] = 32'h66;
    run_op(2'd0, 2'd1, 5'd9, 5'd9, 1'b0);
    clr_plan();
    we_q[1] = 1'b1; wa_q[1] = 5'd9; wd_q[1] = 32'h55;
    we_q[2] = 1'b1; wa_q[2] = 5'd9; wd_q[2] = 32'h77;
    run_op(2'd0, 2'd1, 5'd9, 5'd9, 1'b0);

    // start pulses in RD_A and DONE must be ignored
    clr_plan();
    run_op(2'd1, 2'd0, 5'd8, 5'd31, 1'b1);

    // Reset in RD_B aborts the sequence
    start = 1'b1; Src_A = 2'd0; Src_B = 2'd1; rs = 5'd8; rt = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_val("mid_rst_a", a_out, '0);
    check_val("mid_rst_b", b_out, '0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_done", 32'(done), 32'd0);
    check_val("mid_rst_addr", 32'(rf_rd_addr), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_val("post_rst_idle", 32'({busy, done}), 32'd0);
    end

    // Randomized runs with write-back traffic biased toward the operand indices
    for (int n = 0; n < 60; n++) begin
      logic [1:0] sa, sb;
      logic [IW-1:0] r_s, r_t, ia, ib;
      sa = 2'($urandom); sb = 2'($urandom);
      r_s = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r_t = ($urandom_range(0, 3) == 0) ? r_s : 5'($urandom);
      ia = idx_of(sa, r_s, r_t);
      ib = idx_of(sb, r_s, r_t);
      for (int c = 0; c < 5; c++) begin
        we_q[c] = 1'($urandom);
        case ($urandom_range(0, 3))
          0:       wa_q[c] = ia;
          1:       wa_q[c] = ib;
          2:       wa_q[c] = 5'd0;
          default: wa_q[c] = 5'($urandom);
        endcase
        wd_q[c] = $urandom;
      end
      run_op(sa, sb, r_s, r_t, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
